// File: rtl/photocell_array_detector.sv
// photocell_array_detector
// Multi-channel photocell beam-interruption detector. Each channel
// synchronises and debounces its raw line. It then recognises a complete
// interruption (intact -> blocked -> intact) of at least MIN_BLOCK filtered
// cycles and emits a one-cycle pulse for it. Each pulse also bumps a
// saturating per-channel event counter. A beam blocked for STUCK_CYCLES is
// flagged as stuck until it is restored.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   sensor_in    raw photocell lines (1 = beam intact, 0 = interrupted)
//   enable       0 holds every detection FSM idle
//   clear_count  synchronous clear of all event counters
//   out_pulse    one-cycle pulse per valid interruption
//   stuck        level, channel blocked for >= STUCK_CYCLES
//   event_count  channel i at bits [i*CNT_W +: CNT_W]
module photocell_array_detector #(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned MIN_BLOCK    = 2,
  parameter int unsigned STUCK_CYCLES = 1000,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         sensor_in,
  input  logic                    enable,
  input  logic                    clear_count,
  output logic [N_CH-1:0]         out_pulse,
  output logic [N_CH-1:0]         stuck,
  output logic [N_CH*CNT_W-1:0]   event_count
);

  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned BLK_W = $clog2(STUCK_CYCLES + 1);

  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_MIN    = BLK_W'(MIN_BLOCK);
  localparam logic [BLK_W-1:0] BLK_PRESTK = BLK_W'(STUCK_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_STUCK  = BLK_W'(STUCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BLOCKED = 2'd1,
    ST_STUCK   = 2'd2
  } state_t;

  genvar gi;
  for (gi = 0; gi < int'(N_CH); gi++) begin : g_ch
    logic             r_sync1;
    logic             r_sync2;
    logic             r_filt;
    logic [DEB_W-1:0] r_deb_cnt;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [BLK_W-1:0] r_blk_cnt;
    logic [BLK_W-1:0] w_blk_nxt;
    logic             r_stuck;
    logic             w_stuck_nxt;
    logic             r_pulse;
    logic             w_pulse_nxt;
    logic [CNT_W-1:0] r_count;

    // Two-flop synchroniser plus debounce: filt follows the synchronised
    // level only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_sync1   <= 1'b1;
        r_sync2   <= 1'b1;
        r_filt    <= 1'b1;
        r_deb_cnt <= '0;
      end else begin
        r_sync1 <= sensor_in[gi];
        r_sync2 <= r_sync1;
        if (r_sync2 != r_filt) begin
          if (r_deb_cnt == DEB_LAST) begin
            r_filt    <= r_sync2;
            r_deb_cnt <= '0;
          end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
          end
        end else begin
          r_deb_cnt <= '0;
        end
      end
    end

    // Detection FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state   <= ST_IDLE;
        r_blk_cnt <= '0;
        r_stuck   <= 1'b0;
        r_pulse   <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_blk_cnt <= w_blk_nxt;
        r_stuck   <= w_stuck_nxt;
        r_pulse   <= w_pulse_nxt;
      end
    end

    // Next-state logic; disable overrides everything and parks the FSM.
    always_comb begin
      w_state_nxt = r_state;
      w_blk_nxt   = r_blk_cnt;
      w_stuck_nxt = r_stuck;
      w_pulse_nxt = 1'b0;
      if (!enable) begin
        w_state_nxt = ST_IDLE;
        w_blk_nxt   = '0;
        w_stuck_nxt = 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (!r_filt) begin
              w_state_nxt = ST_BLOCKED;
              w_blk_nxt   = BLK_W'(1);
            end
          end
          ST_BLOCKED: begin
            if (!r_filt) begin
              if (r_blk_cnt >= BLK_PRESTK) begin
                w_state_nxt = ST_STUCK;
                w_blk_nxt   = BLK_STUCK;
                w_stuck_nxt = 1'b1;
              end else begin
                w_blk_nxt = r_blk_cnt + BLK_W'(1);
              end
            end else begin
              w_state_nxt = ST_IDLE;
              w_blk_nxt   = '0;
              w_pulse_nxt = (r_blk_cnt >= BLK_MIN);
            end
          end
          ST_STUCK: begin
            if (r_filt) begin
              w_state_nxt = ST_IDLE;
              w_blk_nxt   = '0;
              w_stuck_nxt = 1'b0;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_blk_nxt   = '0;
            w_stuck_nxt = 1'b0;
          end
        endcase
      end
    end

    // Saturating event counter; clear beats a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_count <= '0;
      end else if (clear_count) begin
        r_count <= '0;
      end else if (w_pulse_nxt && (r_count != CNT_MAX)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end

    assign out_pulse[gi]                   = r_pulse;
    assign stuck[gi]                       = r_stuck;
    assign event_count[gi*CNT_W +: CNT_W]  = r_count;
  end

endmodule

// File: tb/tb_photocell_array_detector.sv
// Testbench for photocell_array_detector: directed scenarios plus random
// beam activity, checked against an interruption-level reference model via
// a pulse scoreboard and continuous stuck/count comparisons.
module tb_photocell_array_detector;

  localparam int unsigned N_CH  = 2;
  localparam int unsigned DEB   = 4;
  localparam int unsigned MINB  = 2;
  localparam int unsigned STUCK = 1000;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic                  clk;
  logic                  rst;
  logic [N_CH-1:0]       sensor;
  logic                  enable;
  logic                  clear;
  logic [N_CH-1:0]       out_pulse;
  logic [N_CH-1:0]       stuck;
  logic [N_CH*CNT_W-1:0] event_count;

  photocell_array_detector #(
    .N_CH(N_CH), .DEB_CYCLES(DEB), .MIN_BLOCK(MINB),
    .STUCK_CYCLES(STUCK), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(rst), .sensor_in(sensor), .enable(enable),
    .clear_count(clear), .out_pulse(out_pulse), .stuck(stuck),
    .event_count(event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: level history, disagreement runs, blocked-run lengths.
  typedef struct {
    int                    edge_no;
    logic [N_CH-1:0]       mask;
    logic [N_CH*CNT_W-1:0] cnt;
  } pulse_t;

  pulse_t sb_q[$];
  int     n_edge = 0;
  int     m_hist0 [N_CH];  // most recently sampled raw level
  int     m_hist1 [N_CH];  // level visible to the debouncer
  int     m_filt  [N_CH];
  int     m_dis   [N_CH];  // consecutive samples disagreeing with filt
  int     m_run   [N_CH];  // consecutive enabled cycles seen blocked
  int     m_cnt   [N_CH];
  bit     m_stuck [N_CH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < int'(N_CH); c++) begin
        m_hist0[c] = 1; m_hist1[c] = 1; m_filt[c] = 1; m_dis[c] = 0;
        m_run[c] = 0; m_cnt[c] = 0; m_stuck[c] = 0;
      end
      sb_q.delete();
    end else begin
      logic [N_CH-1:0]       exp_mask;
      logic [N_CH*CNT_W-1:0] exp_cnt;
      int                    s_old;
      int                    f_old;
      pulse_t                e;
      n_edge++;
      exp_mask = '0;
      for (int c = 0; c < int'(N_CH); c++) begin
        s_old = m_hist1[c];
        f_old = m_filt[c];
        m_hist1[c] = m_hist0[c];
        m_hist0[c] = int'(sensor[c]);
        if (s_old != f_old) begin
          m_dis[c]++;
          if (m_dis[c] == int'(DEB)) begin
            m_filt[c] = s_old;
            m_dis[c]  = 0;
          end
        end else begin
          m_dis[c] = 0;
        end
        if (!enable) begin
          m_run[c] = 0;
        end else if (f_old == 0) begin
          if (m_run[c] < int'(STUCK)) m_run[c]++;
        end else begin
          if (m_run[c] >= int'(MINB) && m_run[c] < int'(STUCK)) exp_mask[c] = 1'b1;
          m_run[c] = 0;
        end
        m_stuck[c] = enable && (m_run[c] >= int'(STUCK));
        if (clear) m_cnt[c] = 0;
        else if (exp_mask[c] && m_cnt[c] < CMAX) m_cnt[c]++;
        exp_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
      end
      if (exp_mask != '0) begin
        e.edge_no = n_edge;
        e.mask    = exp_mask;
        e.cnt     = exp_cnt;
        sb_q.push_back(e);
      end
    end
  end

  // Monitor: pulse scoreboard plus continuous stuck/count checks.
  logic [N_CH-1:0]       mon_stuck;
  logic [N_CH*CNT_W-1:0] mon_cnt;
  pulse_t                mon_e;

  always @(negedge clk) begin
    for (int c = 0; c < int'(N_CH); c++) begin
      mon_stuck[c]               = m_stuck[c];
      mon_cnt[c*CNT_W +: CNT_W]  = CNT_W'(m_cnt[c]);
    end
    while (sb_q.size() > 0 && sb_q[0].edge_no < n_edge) begin
      mon_e = sb_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL pulse_missing: got none expected mask %0h (edge %0d)", mon_e.mask, mon_e.edge_no);
    end
    if (sb_q.size() > 0 && sb_q[0].edge_no == n_edge) begin
      mon_e = sb_q.pop_front();
      chk("pulse_mask", 64'(out_pulse), 64'(mon_e.mask));
      chk("pulse_count", 64'(event_count), 64'(mon_e.cnt));
    end else if (out_pulse != '0) begin
      chk("pulse_unexpected", 64'(out_pulse), 64'd0);
    end
    chk("stuck", 64'(stuck), 64'(mon_stuck));
    chk("count", 64'(event_count), 64'(mon_cnt));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; sensor = '1; enable = 1'b1; clear = 1'b0;
    ticks(3);
    chk("rst_pulse", 64'(out_pulse), 64'd0);
    chk("rst_stuck", 64'(stuck), 64'd0);
    chk("rst_count", 64'(event_count), 64'd0);
    rst = 1'b0;
    ticks(4);

    // Single interruption on channel 0 with exact pulse latency.
    sensor[0] = 1'b0;
    ticks(12);
    sensor[0] = 1'b1;
    ticks(6);
    chk("lat_early", 64'(out_pulse), 64'd0);
    tick();
    chk("lat_pulse", 64'(out_pulse), 64'b01);
    tick();
    chk("lat_after", 64'(out_pulse), 64'd0);
    chk("first_cnt0", 64'(event_count[0 +: CNT_W]), 64'd1);
    chk("first_cnt1", 64'(event_count[CNT_W +: CNT_W]), 64'd0);
    ticks(4);

    // Glitch shorter than the debounce window.
    sensor[0] = 1'b0;
    ticks(3);
    sensor[0] = 1'b1;
    ticks(15);
    chk("glitch_cnt0", 64'(event_count[0 +: CNT_W]), 64'd1);

    // Stuck beam on channel 1.
    sensor[1] = 1'b0;
    ticks(1020);
    chk("stuck_set", 64'(stuck), 64'b10);
    sensor[1] = 1'b1;
    ticks(12);
    chk("stuck_clr", 64'(stuck), 64'd0);
    chk("stuck_cnt1", 64'(event_count[CNT_W +: CNT_W]), 64'd0);

    // Both channels released together.
    sensor = '0;
    ticks(10);
    sensor = '1;
    ticks(7);
    chk("dual_pulse", 64'(out_pulse), 64'b11);
    ticks(6);

    // Disable during a blocked interval: no pulse on release.
    sensor[0] = 1'b0;
    ticks(10);
    enable = 1'b0;
    ticks(2);
    sensor[0] = 1'b1;
    ticks(10);
    enable = 1'b1;
    ticks(10);
    chk("dis_cnt0", 64'(event_count[0 +: CNT_W]), 64'd2);

    // Random activity: glitches, interruptions, clears and enable drops.
    for (int it = 0; it < 400; it++) begin
      for (int c = 0; c < int'(N_CH); c++)
        sensor[c] = ($urandom_range(0, 99) < 55);
      clear  = ($urandom_range(0, 99) < 4);
      enable = ($urandom_range(0, 99) >= 5);
      tick();
      clear = 1'b0;
      ticks(int'($urandom_range(1, 14)));
      enable = 1'b1;
    end
    sensor = '1; enable = 1'b1; clear = 1'b0;
    ticks(20);

    // Drive channel 0 into saturation.
    for (int n = 0; n < CMAX + 3; n++) begin
      sensor[0] = 1'b0;
      ticks(8);
      sensor[0] = 1'b1;
      ticks(10);
    end
    chk("sat_cnt0", 64'(event_count[0 +: CNT_W]), 64'(CMAX));

    // Clear on the same edge as a pulse: pulse stays, count goes to 0.
    sensor[0] = 1'b0;
    ticks(8);
    sensor[0] = 1'b1;
    ticks(6);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_pulse", 64'(out_pulse[0]), 64'd1);
    chk("clr_cnt0", 64'(event_count[0 +: CNT_W]), 64'd0);
    ticks(10);

    // Give channel 1 a count, then reset asynchronously mid-block.
    sensor[1] = 1'b0;
    ticks(8);
    sensor[1] = 1'b1;
    ticks(12);
    sensor[0] = 1'b0;
    ticks(10);
    rst = 1'b1;
    #1;
    chk("arst_pulse", 64'(out_pulse), 64'd0);
    chk("arst_stuck", 64'(stuck), 64'd0);
    chk("arst_count", 64'(event_count), 64'd0);
    sensor[0] = 1'b1;
    ticks(3);
    rst = 1'b0;
    ticks(15);
    chk("arst_nopulse_cnt", 64'(event_count), 64'd0);

    ticks(3);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/photocell_array_detector.md
Name: photocell_array_detector

Overview:
- Multi-channel successor to the single-beam photocell pulse FSM in the queue-management front end.
- Per channel: synchronises and debounces a raw photocell line, then recognises a complete beam interruption (beam intact -> blocked -> intact).
- For each valid interruption it emits a one-cycle pulse and increments a per-channel saturating event counter.
- Flags beams that stay blocked too long as stuck. Pulses feed the customer-counting logic; stuck flags feed the status display.

Parameters:
- N_CH, 2, number of independent photocell channels (>=1).
- DEB_CYCLES, 4, consecutive stable synchronised samples needed before the filtered level changes (>=1).
- MIN_BLOCK, 2, minimum filtered-blocked cycles for an interruption to count (>=1).
- STUCK_CYCLES, 1000, filtered-blocked cycles after which the channel is declared stuck (> MIN_BLOCK).
- CNT_W, 8, width of each per-channel event counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- sensor_in  input  N_CH  raw photocell lines, asynchronous. 1 = beam intact, 0 = beam interrupted.
- enable  input  1  when 0, detection FSMs are held idle.
- clear_count  input  1  synchronous clear of all event counters.
- out_pulse  output  N_CH  one-cycle pulse per valid interruption, registered.
- stuck  output  N_CH  level; channel blocked for >= STUCK_CYCLES.
- event_count  output  N_CH*CNT_W  channel i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (async, active-high), per channel:
  - sync flops = 1, filtered level = 1, debounce counter = 0, block counter = 0, state = IDLE.
  - out_pulse = 0, stuck = 0, event_count = 0.
- Synchroniser: 2-flop per channel; s_i is the second flop output.
- Debounce:
  - While s_i != filt_i, deb_cnt increments each cycle.
  - When s_i != filt_i and deb_cnt == DEB_CYCLES-1: filt_i <= s_i and deb_cnt <= 0.
  - Any cycle with s_i == filt_i clears deb_cnt to 0.
  - Glitches shorter than DEB_CYCLES cycles never reach filt.
- Latency: a sensor_in change first sampled at edge k updates filt at edge k+1+DEB_CYCLES. The resulting out_pulse is registered at edge k+2+DEB_CYCLES (6 edges at defaults).
- FSM per channel (states IDLE, BLOCKED, STUCK):
  - IDLE: filt=0 and enable=1 -> BLOCKED, blk_cnt <= 1.
  - BLOCKED, filt=0: blk_cnt <= blk_cnt+1, saturating at STUCK_CYCLES. When blk_cnt reaches STUCK_CYCLES -> STUCK, stuck <= 1.
  - BLOCKED, filt=1: -> IDLE, blk_cnt <= 0. If blk_cnt >= MIN_BLOCK, out_pulse <= 1 for exactly one cycle and the event counter increments; otherwise no pulse.
  - STUCK, filt=1: -> IDLE, stuck <= 0, no pulse, counter unchanged.
  - STUCK, filt=0: remain.
- out_pulse is 0 in every cycle not listed above. Two pulses on one channel are always separated by at least 2*DEB_CYCLES cycles.
- enable=0:
  - All FSMs are forced to IDLE next edge; blk_cnt <= 0, stuck <= 0, out_pulse <= 0.
  - Synchroniser and debounce keep running.
  - On re-enable, a channel whose filt is already 0 enters BLOCKED and counts from 1.
- Event counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - clear_count=1 sets all counters to 0 next edge. Clear wins over a simultaneous increment; the pulse itself is still emitted.
- Channels are fully independent. Simultaneous pulses on several channels are all emitted in the same cycle.
- Reset asserted mid-interruption: everything returns to reset values immediately. No pulse is produced for the aborted interruption, even if the beam is later restored.

Test Plan:
- Reset, then sensor_in[0]=0 for 12 cycles, then 1 -> exactly one out_pulse[0] high for 1 cycle, 6 edges after the rising edge is sampled; event_count[7:0]=1; channel 1 unaffected.
- Glitch: sensor_in[0]=0 for 3 cycles (DEB_CYCLES=4) -> no pulse, filt never changes, count stays 0.
- Stuck: sensor_in[1]=0 for 1010+ cycles -> stuck[1]=1 once blk_cnt hits 1000. Then sensor_in[1]=1 -> stuck[1]=0 after debounce, no pulse, count unchanged.
- Saturation/clear: CNT_W=2, 5 valid interruptions -> count 3 with no wrap. clear_count asserted on the same edge as a 6th pulse -> pulse seen, count=0.
- Both channels interrupted and released simultaneously -> out_pulse=2'b11 in the same cycle, both counts increment.
- enable=0 during a blocked interval, released, then enable=1 -> no pulse. Reset asserted mid-block -> outputs 0 asynchronously, no pulse on later release.
